// File: rtl/exec_unit_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exec_unit_mc                                                 |
// | Description : Execute-stage ALU with operand forwarding and iterative      |
// |               MUL/DIV/REM behind valid/ready handshakes; outputs are       |
// |               registered.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exec_unit_mc #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [1:0]         fwd_sel_a,
    input  logic [1:0]         fwd_sel_b,
    input  logic [WIDTH-1:0]   fwd_ex_mem,
    input  logic [WIDTH-1:0]   fwd_mem_wb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ltz,
    output logic               ofl,
    output logic               err,
    output logic               busy
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_XOR = 4'b0011;
    localparam logic [3:0] c_OP_ROL = 4'b0100;
    localparam logic [3:0] c_OP_SLL = 4'b0101;
    localparam logic [3:0] c_OP_ROR = 4'b0110;
    localparam logic [3:0] c_OP_SRL = 4'b0111;
    localparam logic [3:0] c_OP_SEQ = 4'b1000;
    localparam logic [3:0] c_OP_SLT = 4'b1001;
    localparam logic [3:0] c_OP_SLE = 4'b1010;
    localparam logic [3:0] c_OP_SCO = 4'b1011;
    localparam logic [3:0] c_OP_MUL = 4'b1100;
    localparam logic [3:0] c_OP_DIV = 4'b1101;
    localparam logic [3:0] c_OP_REM = 4'b1110;

    localparam logic [1:0] c_MOP_MUL = 2'b00;
    localparam logic [1:0] c_MOP_DIV = 2'b01;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_CALC = 1'b1;

    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [1:0]         r_mop;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_acc;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ltz;
    logic               r_ofl;
    logic               r_err;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SHAMT_W-1:0] w_shamt;
    logic [SHAMT_W-1:0] w_nshamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_btr;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_ofl;
    logic               w_is_multi;
    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH-1:0]   w_mul_acc;
    logic               w_q;
    logic [WIDTH-1:0]   w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_divz;
    logic [WIDTH-1:0]   w_new_res;
    logic               w_new_ofl;
    logic               w_new_err;

    always_comb begin
        w_a = src_a;
        case (fwd_sel_a)
            2'b01:   w_a = fwd_mem_wb;
            2'b10:   w_a = fwd_ex_mem;
            default: w_a = src_a;
        endcase
        w_b = src_b;
        case (fwd_sel_b)
            2'b01:   w_b = fwd_mem_wb;
            2'b10:   w_b = fwd_ex_mem;
            default: w_b = src_b;
        endcase
    end

    // Rotates combine a left and right shift; (-s mod WIDTH) makes s=0 degenerate to A|A.
    assign w_shamt  = w_b[SHAMT_W-1:0];
    assign w_nshamt = SHAMT_W'(0) - w_shamt;
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff   = w_a - w_b;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_btr
            assign w_btr[gi] = w_a[WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        w_sc_res = '0;
        w_sc_ofl = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_ofl = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ofl = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_AND: w_sc_res = w_a & w_b;
            c_OP_XOR: w_sc_res = w_a ^ w_b;
            c_OP_ROL: w_sc_res = (w_a << w_shamt) | (w_a >> w_nshamt);
            c_OP_SLL: w_sc_res = w_a << w_shamt;
            c_OP_ROR: w_sc_res = (w_a >> w_shamt) | (w_a << w_nshamt);
            c_OP_SRL: w_sc_res = w_a >> w_shamt;
            c_OP_SEQ: w_sc_res = WIDTH'(w_a == w_b);
            c_OP_SLT: w_sc_res = WIDTH'($signed(w_a) < $signed(w_b));
            c_OP_SLE: w_sc_res = WIDTH'($signed(w_a) <= $signed(w_b));
            c_OP_SCO: w_sc_res = WIDTH'(w_sum[WIDTH]);
            default:  w_sc_res = w_btr;
        endcase
    end

    assign w_is_multi = (op == c_OP_MUL) || (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_in_ready = (r_state == c_S_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept   = in_valid && w_in_ready;

    // MUL: r_x = multiplicand shifting left, r_y = multiplier shifting right.
    // DIV/REM: r_x = dividend shifting out / quotient shifting in, r_acc = partial remainder.
    assign w_mul_acc  = r_acc + (r_y[0] ? r_x : '0);
    assign w_q        = ({r_acc, r_x[WIDTH-1]} >= {1'b0, r_y});
    assign w_trial    = {r_acc[WIDTH-2:0], r_x[WIDTH-1]} - r_y;
    assign w_rem_next = w_q ? w_trial : {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
    assign w_divz     = (r_y == '0);

    always_comb begin
        w_new_res = w_sc_res;
        w_new_ofl = w_sc_ofl;
        w_new_err = w_sc_ofl;
        if (r_state == c_S_CALC) begin
            w_new_ofl = 1'b0;
            case (r_mop)
                c_MOP_MUL: begin
                    w_new_res = w_mul_acc;
                    w_new_err = 1'b0;
                end
                c_MOP_DIV: begin
                    w_new_res = {r_x[WIDTH-2:0], w_q};
                    w_new_err = w_divz;
                end
                default: begin
                    w_new_res = w_rem_next;
                    w_new_err = w_divz;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_mop       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ltz       <= 1'b0;
            r_ofl       <= 1'b0;
            r_err       <= 1'b0;
        end else if (flush) begin
            r_state     <= c_S_IDLE;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_multi) begin
                            r_state <= c_S_CALC;
                            r_cnt   <= '0;
                            r_mop   <= op[1:0];
                            r_x     <= w_a;
                            r_y     <= w_b;
                            r_acc   <= '0;
                        end else begin
                            r_result    <= w_new_res;
                            r_zero      <= (w_new_res == '0);
                            r_ltz       <= w_new_res[WIDTH-1];
                            r_ofl       <= w_new_ofl;
                            r_err       <= w_new_err;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt + SHAMT_W'(1);
                    if (r_mop == c_MOP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_x   <= r_x << 1;
                        r_y   <= r_y >> 1;
                    end else begin
                        r_acc <= w_rem_next;
                        r_x   <= {r_x[WIDTH-2:0], w_q};
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= c_S_IDLE;
                        r_cnt       <= '0;
                        r_result    <= w_new_res;
                        r_zero      <= (w_new_res == '0);
                        r_ltz       <= w_new_res[WIDTH-1];
                        r_ofl       <= w_new_ofl;
                        r_err       <= w_new_err;
                        r_out_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ltz       = r_ltz;
    assign ofl       = r_ofl;
    assign err       = r_err;
    assign busy      = (r_state == c_S_CALC);

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_exec_unit_mc                                              |
// | Description : Randomised self-checking bench for exec_unit_mc (WIDTH=16).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_exec_unit_mc;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] fwd_ex_mem;
    logic [15:0] fwd_mem_wb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        ltz;
    logic        ofl;
    logic        err;
    logic        busy;

    int          n_vec;
    int          n_err;
    logic [15:0] last_res;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          selb;
        logic [15:0] res;
        logic        e;
    } dir_t;

    exec_unit_mc #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .fwd_ex_mem (fwd_ex_mem),
        .fwd_mem_wb (fwd_mem_wb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .ltz        (ltz),
        .ofl        (ofl),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {err, ofl, result} from plain integer arithmetic.
    function automatic logic [17:0] ref_model(input logic [3:0] f_op, input logic [15:0] a,
                                              input logic [15:0] b);
        longint u, v, sa, sb, r;
        logic o, e;
        int s;
        logic [15:0] res;
        u = a; v = b; sa = $signed(a); sb = $signed(b);
        s = int'(b[3:0]); o = 1'b0; e = 1'b0; r = 0;
        case (f_op)
            4'd0:  begin r = u + v; o = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1:  begin r = u - v; o = (sa - sb > 32767) || (sa - sb < -32768); end
            4'd2:  r = u & v;
            4'd3:  r = u ^ v;
            4'd4:  r = (u << s) | (u >> (16 - s));
            4'd5:  r = u << s;
            4'd6:  r = (u >> s) | (u << (16 - s));
            4'd7:  r = u >> s;
            4'd8:  r = (u == v) ? 1 : 0;
            4'd9:  r = (sa < sb) ? 1 : 0;
            4'd10: r = (sa <= sb) ? 1 : 0;
            4'd11: r = ((u + v) > 65535) ? 1 : 0;
            4'd12: r = u * v;
            4'd13: begin r = (v == 0) ? 65535 : u / v; e = (v == 0); end
            4'd14: begin r = (v == 0) ? u : u % v; e = (v == 0); end
            default: for (int i = 0; i < 16; i++) if (a[i]) r = r | (longint'(1) << (15 - i));
        endcase
        res = r[15:0];
        return {o | e, o, res};
    endfunction

    // Issues one op with out_ready=1 and checks the result once it appears.
    // sel modes 0..3 force the forwarding select, anything larger picks one at random.
    task automatic run_op(input logic [3:0] t_op, input logic [15:0] a, input logic [15:0] b,
                          input int sel_a_mode, input int sel_b_mode);
        logic [17:0] exp;
        logic [1:0]  sa, sb;
        int          lat;
        logic        hs_bad;
        logic        multi;
        sa = (sel_a_mode > 3) ? 2'($urandom_range(0, 3)) : 2'(sel_a_mode);
        sb = (sel_b_mode > 3) ? 2'($urandom_range(0, 3)) : 2'(sel_b_mode);
        if (sa == sb && (sa == 2'b01 || sa == 2'b10) && a != b) sb = 2'b00;
        src_a = 16'($urandom); src_b = 16'($urandom);
        fwd_ex_mem = 16'($urandom); fwd_mem_wb = 16'($urandom);
        case (sa)
            2'b01:   fwd_mem_wb = a;
            2'b10:   fwd_ex_mem = a;
            default: src_a = a;
        endcase
        case (sb)
            2'b01:   fwd_mem_wb = b;
            2'b10:   fwd_ex_mem = b;
            default: src_b = b;
        endcase
        fwd_sel_a = sa; fwd_sel_b = sb; op = t_op; in_valid = 1'b1; out_ready = 1'b1;
        exp = ref_model(t_op, a, b);
        multi = (t_op == 4'd12) || (t_op == 4'd13) || (t_op == 4'd14);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_idle op=%h got=%b want=1", t_op, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom);
        src_a = 16'($urandom); src_b = 16'($urandom);
        fwd_ex_mem = 16'($urandom); fwd_mem_wb = 16'($urandom);
        if (multi) begin
            lat = 0; hs_bad = 1'b0;
            while (out_valid !== 1'b1 && lat < 40) begin
                if (busy !== 1'b1 || in_ready !== 1'b0) hs_bad = 1'b1;
                @(posedge clk); #1;
                lat++;
            end
            n_vec++;
            if (lat != 16 || hs_bad) begin
                n_err++;
                $display("FAIL multi_latency op=%h got lat=%0d hs_bad=%b want lat=16 hs_bad=0",
                         t_op, lat, hs_bad);
            end
        end
        n_vec++;
        if ({out_valid, err, ofl, zero, ltz, result} !==
            {1'b1, exp[17], exp[16], exp[15:0] == 16'h0, exp[15], exp[15:0]}) begin
            n_err++;
            $display("FAIL op_result op=%h a=%h b=%h got v=%b res=%h err=%b ofl=%b z=%b n=%b want res=%h err=%b ofl=%b",
                     t_op, a, b, out_valid, result, err, ofl, zero, ltz, exp[15:0], exp[17], exp[16]);
        end
        last_res = exp[15:0];
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0;
        src_a = '0; src_b = '0; fwd_sel_a = '0; fwd_sel_b = '0; fwd_ex_mem = '0; fwd_mem_wb = '0;
        #2;
        n_vec++;
        if ({out_valid, busy, result, zero, ltz, ofl, err} !== 22'h0) begin
            n_err++;
            $display("FAIL reset_state got v=%b busy=%b res=%h flags=%b%b%b%b want all 0",
                     out_valid, busy, result, zero, ltz, ofl, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        dir_t tbl[8];
        tbl[0] = '{4'd0,  16'h7FFF, 16'h0001, 0, 16'h8000, 1'b1};
        tbl[1] = '{4'd12, 16'h0123, 16'h0010, 2, 16'h1230, 1'b0};
        tbl[2] = '{4'd13, 16'h0064, 16'h0007, 0, 16'h000E, 1'b0};
        tbl[3] = '{4'd14, 16'h0064, 16'h0007, 0, 16'h0002, 1'b0};
        tbl[4] = '{4'd13, 16'h0064, 16'h0000, 0, 16'hFFFF, 1'b1};
        tbl[5] = '{4'd14, 16'h0064, 16'h0000, 0, 16'h0064, 1'b1};
        tbl[6] = '{4'd6,  16'h8001, 16'h0001, 1, 16'hC000, 1'b0};
        tbl[7] = '{4'd15, 16'h0001, 16'h0000, 0, 16'h8000, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, tbl[i].selb);
            n_vec++;
            if (result !== tbl[i].res || err !== tbl[i].e) begin
                n_err++;
                $display("FAIL directed_%0d got res=%h err=%b want res=%h err=%b",
                         i, result, err, tbl[i].res, tbl[i].e);
            end
            if (i == 0) begin
                n_vec++;
                if (ofl !== 1'b1 || ltz !== 1'b1) begin
                    n_err++;
                    $display("FAIL add_ovf_flags got ofl=%b ltz=%b want 1 1", ofl, ltz);
                end
            end
        end
        run_op(4'd9, 16'hFFFF, 16'h0001, 3, 3);
        n_vec++;
        if (result !== 16'h0001) begin
            n_err++;
            $display("FAIL slt_neg got=%h want=0001", result);
        end
    endtask

    task automatic test_single_random();
        logic [3:0]  t_op;
        logic [15:0] a, b;
        for (int i = 0; i < 60; i++) begin
            t_op = 4'($urandom_range(0, 12));
            if (t_op == 4'd12) t_op = 4'd15;
            a = 16'($urandom); b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'h7FFF + 16'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hFFFF;
            if ($urandom_range(0, 7) == 0) b = a;
            run_op(t_op, a, b, 9, 9);
        end
    endtask

    task automatic test_multi_random();
        logic [3:0]  t_op;
        logic [15:0] a, b;
        for (int i = 0; i < 12; i++) begin
            t_op = 4'($urandom_range(12, 14));
            a = 16'($urandom);
            b = 16'($urandom >> $urandom_range(16, 31));
            if ($urandom_range(0, 4) == 0) b = 16'h0000;
            run_op(t_op, a, b, 9, 9);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 9, 9);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL consume_clear got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic stable;
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00;
        op = 4'd1; src_a = 16'd5; src_b = 16'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b1 || result !== 16'h0002) begin
            n_err++;
            $display("FAIL bp_first got v=%b res=%h want v=1 res=0002", out_valid, result);
        end
        op = 4'd3; src_a = 16'hF0F0; src_b = 16'h0FF0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 16'h0002) stable = 1'b0;
        end
        n_vec++;
        if (!stable) begin
            n_err++;
            $display("FAIL bp_hold got res=%h v=%b in_ready=%b want held 0002 and in_ready 0",
                     result, out_valid, in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || result !== 16'hFF00) begin
            n_err++;
            $display("FAIL bp_second got v=%b res=%h want v=1 res=FF00", out_valid, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic seen;
        run_op(4'd0, 16'h1234, 16'h1111, 0, 0);
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00;
        op = 4'd12; src_a = 16'd3; src_b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre got in_ready=%b busy=%b want 0 1", in_ready, busy);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== last_res) begin
            n_err++;
            $display("FAIL flush_kill got busy=%b v=%b res=%h want 0 0 res=%h",
                     busy, out_valid, result, last_res);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL flush_no_result got late out_valid/busy want none");
        end
        run_op(4'd3, 16'hAAAA, 16'h5555, 9, 9);
        out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || result !== 16'hFFFF) begin
            n_err++;
            $display("FAIL flush_pending got v=%b res=%h want v=0 res=FFFF", out_valid, result);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00;
        op = 4'd13; src_a = 16'd100; src_b = 16'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, busy, result, zero, ltz, ofl, err} !== 22'h0) begin
            n_err++;
            $display("FAIL async_reset got v=%b busy=%b res=%h flags=%b%b%b%b want all 0",
                     out_valid, busy, result, zero, ltz, ofl, err);
        end
        @(negedge clk) rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_abort got late out_valid/busy want none");
        end
        run_op(4'd0, 16'($urandom), 16'($urandom), 9, 9);
        run_op(4'd14, 16'd1000, 16'd33, 9, 9);
    endtask

    initial begin
        n_vec = 0; n_err = 0; last_res = '0;
        test_reset();
        test_directed();
        test_single_random();
        test_multi_random();
        test_back_to_back();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
Parametrised, multi-cycle successor of the processor's execute-stage ALU. It holds single-cycle integer ops and operand forwarding, and adds iterative multiply, divide and remainder. A valid/ready handshake on both sides lets the pipeline stall on long ops instead of assuming one-cycle completion. The block sits between the ID/EX and EX/MEM pipeline registers. Its results and flags are registered.

Parameters:
WIDTH, 16, datapath width in bits (≥4, power of two)
SHAMT_W, 4, shift-amount width; must equal log2(WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of in-flight op and pending result
in_valid  in  1  operation presented
in_ready  out  1  operation accepted when in_valid & in_ready
op  in  4  operation code (see Behaviour)
src_a  in  WIDTH  register operand A
src_b  in  WIDTH  register operand B / immediate
fwd_sel_a  in  2  A select: 00 src_a, 01 fwd_mem_wb, 10 fwd_ex_mem, 11 src_a
fwd_sel_b  in  2  same encoding for B
fwd_ex_mem  in  WIDTH  forwarded EX/MEM ALU result
fwd_mem_wb  in  WIDTH  forwarded MEM/WB write-back data
out_valid  out  1  result register holds a result
out_ready  in  1  consumer takes result when out_valid & out_ready
result  out  WIDTH  registered result
zero  out  1  result == 0
ltz  out  1  result[WIDTH-1]
ofl  out  1  signed overflow (ADD/SUB only)
err  out  1  ofl or divide-by-zero
busy  out  1  state == CALC

Behaviour:
- Operand capture: forwarding muxes resolve A and B combinationally. Resolved values are captured on accept. Later changes on the inputs have no effect.
- Op codes (A, B = resolved operands):
  - 0000 ADD A+B; 0001 SUB A−B; 0010 AND; 0011 XOR
  - 0100 ROL; 0101 SLL; 0110 ROR; 0111 SRL. All shifts and rotates by B[SHAMT_W-1:0].
  - 1000 SEQ A==B; 1001 SLT A<B signed; 1010 SLE A<=B signed; 1011 SCO carry-out of A+B. Set ops return 1 or 0.
  - 1100 MUL: low WIDTH bits of unsigned A*B.
  - 1101 DIV: unsigned A/B. 1110 REM: unsigned A%B.
  - 1111 BTR: bit-reverse of A.
- FSM states: IDLE and CALC.
- in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
- Single-cycle ops (all except 1100–1110): accepted in IDLE. result, flags and out_valid=1 are written at the next edge, giving latency 1. Back-to-back issue is allowed at full throughput while out_ready=1.
- MUL/DIV/REM: accept moves IDLE→CALC and clears cnt.
  - Each CALC cycle does one shift-add step (MUL) or one restoring-division step (DIV/REM). cnt increments.
  - When cnt==WIDTH-1, the edge writes result and flags, sets out_valid=1 and returns to IDLE.
  - Latency is WIDTH cycles from accept to out_valid; in_ready is 0 throughout.
  - Accept requires the output register to be empty or draining, so completion never collides with an unconsumed result.
- Divide by zero: DIV returns all ones, REM returns A, err=1. The operation still takes WIDTH cycles.
- ofl: set on signed overflow for ADD/SUB, 0 for all other ops. err = ofl | div-by-zero.
- Output hold: result and flags stay stable while out_valid & ~out_ready. out_valid clears on consume unless a new result is written in the same edge.
- flush (sync):
  - State goes to IDLE, out_valid=0 and cnt=0.
  - Overrides an accept or completion in the same cycle.
  - result and flags keep their old values.
- Reset (async, active-low):
  - State=IDLE, cnt=0.
  - out_valid=0, result=0, zero=0, ltz=0, ofl=0, err=0, busy=0.
  - Reset mid-CALC aborts the operation, and no result is produced.
- fwd_sel=11 is treated as 00. It never drives X or Z.

Test Plan:
- WIDTH=16, ADD A=0x7FFF B=0x0001, out_ready=1 → next cycle out_valid=1, result=0x8000, ofl=1, err=1, ltz=1.
- MUL A=0x0123 B=0x0010, fwd_sel_b=10 with fwd_ex_mem=0x0010 → busy for 16 cycles, then result=0x1230, and in_ready=0 throughout CALC.
- DIV A=0x0064 B=0x0007 → result=0x000E. REM with the same operands → 0x0002. DIV by 0 → 0xFFFF, err=1. REM by 0 → 0x0064, err=1.
- Back-pressure: SUB 5−3 issued with out_ready=0 → result=0x0002 holds, in_ready=0 and a second op is not accepted. When out_ready=1 the second op is accepted in that cycle.
- Rotate and bit-reverse: ROR 0x8001 by 1 → 0xC000. BTR 0x0001 → 0x8000. SLT 0xFFFF vs 0x0001 → 1.
- flush at cycle 5 of a MUL → busy=0, out_valid stays 0. rst low mid-DIV → all outputs 0 immediately; after release the block accepts a new op.
